// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Shared definitions for the systolic result drain: default array
//             geometry, drain FSM state encoding and a width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int DEFAULT_ROWS       = 3;
    localparam int DEFAULT_COLS       = 3;
    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } drain_state_e;

    // Bits needed to index n items, never less than one so that a
    // degenerate 1-row or 1-column array still has a real index port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/drain_index_counter.sv
`default_nettype none
// ============================================================================
//  Module   : drain_index_counter
//  Purpose  : Row-major row/column walker for the result drain. Column wraps
//             COLS-1 -> 0 and carries into the row; the row wraps to 0 after
//             the final element so the counter is back at (0,0) afterwards.
//  Ports    : clk, rstn      - clock, async active-low reset
//             clear          - force (0,0); wins over advance
//             advance        - step to the next element
//             row, col       - current element indices
//             last           - current element is (ROWS-1, COLS-1)
//  Revision : 1.0 - initial release
// ============================================================================
module drain_index_counter #(
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int ROW_W = 2,
    parameter int COL_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule : drain_index_counter
`default_nettype wire

// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_result_drain
//  Purpose  : Snapshots the ROWS x COLS signed accumulators on start and
//             streams them out row-major over valid/ready, tagged with row,
//             column and last. The array may keep accumulating meanwhile.
//  Ports    : clk, rstn      - clock, async active-low reset
//             start          - snapshot + drain request (IDLE only)
//             flush          - synchronous abort back to IDLE, no done
//             in_data        - flattened accumulators, (r,c) at
//                              [(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH]
//             out_data/out_row/out_col/out_last/out_spike, out_valid,
//             out_ready      - result stream
//             busy           - STREAM or DONE
//             done           - one-cycle pulse after the final handshake
//  Macro    : DRAIN_SPIKE_EN - when defined, out_spike flags words with
//             signed value >= THRESHOLD; otherwise out_spike is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter  int ROWS       = DEFAULT_ROWS,
    parameter  int COLS       = DEFAULT_COLS,
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int THRESHOLD  = 0,
    localparam int ROW_W      = clog2_min1(ROWS),
    localparam int COL_W      = clog2_min1(COLS)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic                            flush,
    input  logic [ROWS*COLS*DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ROW_W-1:0]                out_row,
    output logic [COL_W-1:0]                out_col,
    output logic                            out_last,
    output logic                            out_spike,
    output logic                            busy,
    output logic                            done
);

    drain_state_e state_q, state_d;

    logic                  load;
    logic                  idx_clear;
    logic                  idx_advance;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic                  last;

    logic [DATA_WIDTH-1:0] snap_q [ROWS][COLS];
    logic [DATA_WIDTH-1:0] snap_d [ROWS][COLS];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    load    = 1'b1;
                end
            end
            ST_STREAM: begin
                if (out_ready && last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // start here is deliberately not looked at; the next
                // request is honoured from the first IDLE cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Index walker: parked at (0,0) outside STREAM, so the next drain
    // always starts from the first element. A flush swallows any
    // simultaneous handshake.
    // ------------------------------------------------------------------
    assign idx_clear   = flush || (state_q != ST_STREAM);
    assign idx_advance = (state_q == ST_STREAM) && out_ready && !flush;

    drain_index_counter #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_index (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (idx_clear),
        .advance (idx_advance),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    // ------------------------------------------------------------------
    // Snapshot: written only on the IDLE->STREAM transition, so in_data
    // changes during a drain never reach the output.
    // ------------------------------------------------------------------
    always_comb begin
        snap_d = snap_q;
        if (load) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    snap_d[r][c] = in_data[(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    snap_q[r][c] <= '0;
                end
            end
        end else begin
            snap_q <= snap_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state, so they hold steady
    // while out_ready is low.
    // ------------------------------------------------------------------
    assign out_valid = (state_q == ST_STREAM);
    assign out_data  = out_valid ? snap_q[row][col] : '0;
    assign out_row   = row;
    assign out_col   = col;
    assign out_last  = out_valid && last;
    assign busy      = (state_q == ST_STREAM) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);

`ifdef DRAIN_SPIKE_EN
    // The threshold flag is evaluated once at snapshot time and stored
    // next to each word, so it is registered and travels with out_data.
    localparam logic signed [DATA_WIDTH-1:0] THRESHOLD_S = DATA_WIDTH'(THRESHOLD);

    logic spike_q [ROWS][COLS];
    logic spike_d [ROWS][COLS];

    always_comb begin
        spike_d = spike_q;
        if (load) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    spike_d[r][c] = ($signed(in_data[(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH])
                                     >= THRESHOLD_S);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    spike_q[r][c] <= 1'b0;
                end
            end
        end else begin
            spike_q <= spike_d;
        end
    end

    assign out_spike = out_valid && spike_q[row][col];
`else
    assign out_spike = 1'b0;

    // THRESHOLD has no effect without the spike flag.
    if (THRESHOLD != 0) begin : g_threshold_unused
    end
`endif

endmodule : systolic_result_drain
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_result_drain
//  Purpose  : Scoreboard bench for systolic_result_drain. Stimulus pushes the
//             expected row-major word list on each accepted start; a monitor
//             compares every presented word and pops on handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_result_drain;

    localparam int ROWS   = 3;
    localparam int COLS   = 3;
    localparam int DW     = 16;
    localparam int N      = ROWS * COLS;
    localparam int THRESH = 1;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b0;
    logic [N*DW-1:0] in_data = '0;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic [1:0]      out_row;
    logic [1:0]      out_col;
    logic            out_last;
    logic            out_spike;
    logic            busy;
    logic            done;

    systolic_result_drain #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .DATA_WIDTH (DW),
        .THRESHOLD  (THRESH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .flush     (flush),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_spike (out_spike),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int row;
        int col;
        bit last;
        bit spike;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    bit   exp_done = 1'b0;
    bit   mon_en = 1'b0;
    int   ready_mode = 0;
    int   ready_phase = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_elem(input int idx, input int val);
        logic [DW-1:0] v;
        v = val[DW-1:0];
        in_data[idx*DW +: DW] = v;
    endtask

    // Reference model: row-major list of the words captured at start.
    task automatic push_expected();
        exp_t e;
        logic signed [DW-1:0] w;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w      = in_data[(r*COLS+c)*DW +: DW];
                e.data = w;
                e.row  = r;
                e.col  = c;
                e.last = (r == ROWS-1) && (c == COLS-1);
`ifdef DRAIN_SPIKE_EN
                e.spike = (e.data >= THRESH);
`else
                e.spike = 1'b0;
`endif
                q.push_back(e);
            end
        end
    endtask

    // Downstream ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
                    ready_phase++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (mon_en && rstn) begin
            chk("done", int'(done), int'(exp_done));
            chk("busy", int'(busy), int'(q.size() != 0 || exp_done));
            chk("valid", int'(out_valid), int'(q.size() != 0));
            exp_done = 1'b0;
            if (out_valid && q.size() != 0) begin
                me = q[0];
                chk("data", $signed(out_data), me.data);
                chk("row", int'(out_row), me.row);
                chk("col", int'(out_col), me.col);
                chk("last", int'(out_last), int'(me.last));
                chk("spike", int'(out_spike), int'(me.spike));
                if (out_ready && !flush) begin
                    void'(q.pop_front());
                    pops++;
                    if (me.last) exp_done = 1'b1;
                end
            end
            if (flush) begin
                q.delete();
                exp_done = 1'b0;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((q.size() != 0 || exp_done) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0 || exp_done) begin
            chk("drain_timeout_pending", q.size() + int'(exp_done), 0);
            q.delete();
            exp_done = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 with the DUT idle; returns the same way.
    task automatic do_drain(input bit isolate, input int flush_after);
        int base;
        int n;
        base  = pops;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_expected();
        if (isolate) begin
            for (int i = 0; i < N; i++) set_elem(i, 16'h7FFF);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n = 0;
            while (!exp_done && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            // start during the DONE cycle must be ignored
            @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (flush_after >= 0) begin
            n = 0;
            while (pops < base + flush_after && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
            @(posedge clk);
            #1;
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
        wait_idle(300);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) set_elem(i, i - 4);
    endtask

    task automatic load_random();
        int v;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 5))
                0:       v = 32'h7FFF;
                1:       v = 32'h8000;
                default: v = int'($urandom_range(0, 16'hFFFF));
            endcase
            set_elem(i, v);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with start asserted.
        rstn  = 1'b0;
        start = 1'b1;
        load_ramp();
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_data", int'(out_data), 0);
            chk("rst_last", int'(out_last), 0);
        end
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("idle_valid", int'(out_valid), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic drain, always ready.
        ready_mode = 0;
        @(posedge clk);
        #1;
        load_ramp();
        do_drain(1'b0, -1);

        // Backpressure 1,0,0,1.
        ready_mode  = 1;
        ready_phase = 0;
        load_ramp();
        do_drain(1'b0, -1);

        // Snapshot isolation, start while streaming, start in DONE.
        ready_mode = 0;
        @(posedge clk);
        #1;
        load_ramp();
        do_drain(1'b1, -1);

        // Flush on the 4th transfer cycle, then a fresh drain.
        load_ramp();
        do_drain(1'b0, 3);
        load_ramp();
        do_drain(1'b0, -1);

        // Randomised drains with random backpressure and occasional flush.
        ready_mode = 2;
        for (int k = 0; k < 20; k++) begin
            load_random();
            do_drain(1'b0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        // Asynchronous reset mid-drain.
        ready_mode = 0;
        load_random();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_expected();
        repeat (3) @(posedge clk);
        #3;
        rstn = 1'b0;
        q.delete();
        exp_done = 1'b0;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_data", int'(out_data), 0);
        chk("midrst_done", int'(done), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        load_ramp();
        do_drain(1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_systolic_result_drain
`default_nettype wire
